iob_fp_mul_arbiter: RTL and testbench

- Shares one multi-cycle iob_fp_mul instance between N_REQ independent requesters.
- Grants requesters in round-robin order and sequences the multiplier's start/done handshake.
- Returns the result and flags to the requester that was granted.
- Guards against a hung multiplier with a watchdog counter.

---
 rtl/iob_fp_mul_arbiter_pkg.sv | 18 +
 rtl/iob_fp_mul_arbiter_if.sv | 39 +++
 rtl/iob_rr_arbiter.sv | 39 +++
 rtl/iob_fp_mul_arbiter.sv | 127 ++++++++++++
 tb/tb_iob_fp_mul_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_fp_mul_arbiter_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
package iob_fp_mul_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  function automatic int calc_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_REQ_DEF = 4;
  localparam int ID_W_DEF  = calc_id_w(N_REQ_DEF);

endpackage

// File: rtl/iob_fp_mul_arbiter_if.sv
// Requester and multiplier bus of the arbiter; slave = arbiter view, master = environment view.
interface iob_fp_mul_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*DATA_W-1:0] req_op_a_i;
  logic [N_REQ*DATA_W-1:0] req_op_b_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]       rsp_res_o;
  logic                    rsp_overflow_o;
  logic                    rsp_underflow_o;
  logic                    rsp_exception_o;
  logic                    rsp_timeout_o;
  logic                    busy_o;
  logic                    mul_start_o;
  logic [DATA_W-1:0]       mul_op_a_o;
  logic [DATA_W-1:0]       mul_op_b_o;
  logic                    mul_done_i;
  logic [DATA_W-1:0]       mul_res_i;
  logic                    mul_overflow_i;
  logic                    mul_underflow_i;
  logic                    mul_exception_i;

  modport slave (
    input  req_valid_i, req_op_a_i, req_op_b_i,
    input  mul_done_i, mul_res_i, mul_overflow_i, mul_underflow_i, mul_exception_i,
    output req_ready_o, rsp_valid_o, rsp_res_o, rsp_overflow_o, rsp_underflow_o,
    output rsp_exception_o, rsp_timeout_o, busy_o, mul_start_o, mul_op_a_o, mul_op_b_o
  );

  modport master (
    output req_valid_i, req_op_a_i, req_op_b_i,
    output mul_done_i, mul_res_i, mul_overflow_i, mul_underflow_i, mul_exception_i,
    input  req_ready_o, rsp_valid_o, rsp_res_o, rsp_overflow_o, rsp_underflow_o,
    input  rsp_exception_o, rsp_timeout_o, busy_o, mul_start_o, mul_op_a_o, mul_op_b_o
  );
endinterface

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin pick: first request at or above the pointer, wrapping at N_REQ-1.
module iob_rr_arbiter
  import iob_fp_mul_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = calc_id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_id,
  output logic             o_any
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  // Wrap is a subtract rather than a mask so non-power-of-two N_REQ never indexes a missing bit
  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(i);
      w_idx = (w_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(w_sum - (ID_W+1)'(N_REQ)) : w_sum[ID_W-1:0];
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
      end
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/iob_fp_mul_arbiter.sv
// Shares one multi-cycle FP multiplier between N_REQ requesters with round-robin grant and a watchdog.
module iob_fp_mul_arbiter
  import iob_fp_mul_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  iob_fp_mul_arbiter_if.slave bus
);

  localparam int ID_W = calc_id_w(N_REQ);
  // Last WAIT cycle before timeout: counter value 2**TIMEOUT_W-2 marks the (2**TIMEOUT_W-1)th cycle
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  arb_state_e          r_state, w_state_nxt;
  logic [ID_W-1:0]     r_ptr, r_id, w_gnt_id;
  logic [N_REQ-1:0]    w_gnt;
  logic                w_any, w_wdog_sat;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic [DATA_W-1:0]   r_op_a, r_op_b, r_res, w_sel_a, w_sel_b;
  logic                r_ov, r_un, r_ex, r_to;

  iob_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .i_req (bus.req_valid_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_id  (w_gnt_id),
    .o_any (w_any)
  );

  assign w_wdog_sat = (r_wdog == WDOG_LAST);

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) begin
        w_sel_a = bus.req_op_a_i[k*DATA_W +: DATA_W];
        w_sel_b = bus.req_op_b_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // mul_done_i is only looked at in WAIT; it may still be high from the previous job during START
  always_comb begin
    w_state_nxt     = r_state;
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    bus.mul_start_o = 1'b0;
    bus.busy_o      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        bus.req_ready_o = w_gnt;
        if (w_any) w_state_nxt = START;
      end
      START: begin
        bus.mul_start_o = 1'b1;
        w_state_nxt     = WAIT;
      end
      WAIT: if (bus.mul_done_i || w_wdog_sat) w_state_nxt = RESP;
      RESP: begin
        bus.rsp_valid_o = N_REQ'(1) << r_id;
        w_state_nxt     = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_wdog <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_res  <= '0;
      r_ov   <= 1'b0;
      r_un   <= 1'b0;
      r_ex   <= 1'b0;
      r_to   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_op_a <= w_sel_a;
          r_op_b <= w_sel_b;
          r_id   <= w_gnt_id;
          r_ptr  <= (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
        end
        START: r_wdog <= '0;
        WAIT: begin
          r_wdog <= r_wdog + TIMEOUT_W'(1);
          if (bus.mul_done_i) begin
            r_res <= bus.mul_res_i;
            r_ov  <= bus.mul_overflow_i;
            r_un  <= bus.mul_underflow_i;
            r_ex  <= bus.mul_exception_i;
            r_to  <= 1'b0;
          end else if (w_wdog_sat) begin
            r_res <= '0;
            r_ov  <= 1'b0;
            r_un  <= 1'b0;
            r_ex  <= 1'b0;
            r_to  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mul_op_a_o      = r_op_a;
  assign bus.mul_op_b_o      = r_op_b;
  assign bus.rsp_res_o       = r_res;
  assign bus.rsp_overflow_o  = r_ov;
  assign bus.rsp_underflow_o = r_un;
  assign bus.rsp_exception_o = r_ex;
  assign bus.rsp_timeout_o   = r_to;

endmodule

// File: tb/tb_iob_fp_mul_arbiter.sv
// Directed bench: multiplier stub, timeline-based model of the arbiter, and literal spot checks.
module tb_iob_fp_mul_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int L  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   hung = 1'b0;

  iob_fp_mul_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  iob_fp_mul_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t: timed out waiting", nm, $time);
  endtask

  // Reference single-precision multiply (truncating, denormals flushed); returns {ex,un,ov,res}
  function automatic logic [34:0] fp_ref(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) begin
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
          (ea == 255 && b[30:0] == 0) || (eb == 255 && a[30:0] == 0))
        return {3'b100, 32'h7FC00000};
      return {3'b000, s, 8'hFF, 23'h0};
    end
    if (ea == 0 || eb == 0) return {3'b000, s, 31'h0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else m = p[45:23];
    if (e >= 255) return {3'b001, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b010, s, 31'h0};
    return {3'b000, s, 8'(e), m};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++)
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // Multiplier stub: done rises L cycles after start and stays high until the next start
  int          st_cnt;
  logic        st_done;
  logic [31:0] st_res;
  logic [2:0]  st_flg;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_cnt <= 0; st_done <= 1'b0; st_res <= '0; st_flg <= '0;
    end else if (bus.mul_start_o) begin
      st_cnt  <= L - 1;
      st_done <= 1'b0;
      {st_flg, st_res} <= fp_ref(bus.mul_op_a_o, bus.mul_op_b_o);
    end else if (st_cnt == 1) begin
      st_cnt  <= 0;
      st_done <= 1'b1;
    end else if (st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
    end
  end
  assign bus.mul_done_i      = st_done && !hung;
  assign bus.mul_res_i       = bus.mul_done_i ? st_res : 32'hDEADBEEF;
  assign bus.mul_overflow_i  = bus.mul_done_i ? st_flg[0] : 1'b1;
  assign bus.mul_underflow_i = bus.mul_done_i ? st_flg[1] : 1'b1;
  assign bus.mul_exception_i = bus.mul_done_i ? st_flg[2] : 1'b1;

  // Model state and observations
  int cyc = 0;
  bit m_busy = 1'b0;
  int m_id = 0, m_acc = 0, m_lat = 0, m_ptr = 0;
  logic [31:0] m_opa = '0, m_opb = '0, m_res = '0, p_res = '0;
  logic [3:0]  m_flg = '0, p_flg = '0;  // {ov,un,ex,to}
  int acc_ids[$];
  int last_acc = 0;
  int rsp_cnt = 0;
  logic [3:0]  lr_vec = '0;
  logic [31:0] lr_res = '0;
  logic [3:0]  lr_flg = '0;
  int lr_cyc = 0;

  initial begin : monitor
    logic [N-1:0] e_rdy, e_rsp;
    logic e_start;
    int pk;
    logic [34:0] r;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_busy = 1'b0; m_ptr = 0; m_opa = '0; m_opb = '0; m_res = '0; m_flg = '0;
        chk("rst_ready", bus.req_ready_o, '0);
        chk("rst_rsp_valid", bus.rsp_valid_o, '0);
        chk("rst_busy_start", {bus.busy_o, bus.mul_start_o}, '0);
        chk("rst_rsp_res", bus.rsp_res_o, '0);
        chk("rst_rsp_flags", {bus.rsp_overflow_o, bus.rsp_underflow_o, bus.rsp_exception_o, bus.rsp_timeout_o}, '0);
        chk("rst_mul_op", {bus.mul_op_a_o, bus.mul_op_b_o}, '0);
      end else begin
        pk      = m_busy ? -1 : rr_pick(bus.req_valid_i, m_ptr);
        e_rdy   = (pk >= 0) ? N'(1 << pk) : '0;
        e_start = m_busy && (cyc == m_acc + 1);
        e_rsp   = (m_busy && cyc == m_acc + 2 + m_lat) ? N'(1 << m_id) : '0;
        if (e_rsp != 0) begin m_res = p_res; m_flg = p_flg; end
        chk("req_ready", bus.req_ready_o, e_rdy);
        chk("busy", bus.busy_o, m_busy);
        chk("mul_start", bus.mul_start_o, e_start);
        chk("rsp_valid", bus.rsp_valid_o, e_rsp);
        chk("rsp_res", bus.rsp_res_o, m_res);
        chk("rsp_flags", {bus.rsp_overflow_o, bus.rsp_underflow_o, bus.rsp_exception_o, bus.rsp_timeout_o}, m_flg);
        chk("mul_op", {bus.mul_op_a_o, bus.mul_op_b_o}, {m_opa, m_opb});
        if (bus.rsp_valid_o != 0) begin
          rsp_cnt++;
          lr_vec = bus.rsp_valid_o;
          lr_res = bus.rsp_res_o;
          lr_flg = {bus.rsp_overflow_o, bus.rsp_underflow_o, bus.rsp_exception_o, bus.rsp_timeout_o};
          lr_cyc = cyc;
        end
        for (int k = 0; k < N; k++)
          if (bus.req_ready_o[k] && bus.req_valid_i[k]) begin
            acc_ids.push_back(k);
            last_acc = cyc;
          end
        if (e_rsp != 0) m_busy = 1'b0;
        else if (pk >= 0) begin
          m_busy = 1'b1;
          m_id   = pk;
          m_acc  = cyc;
          m_ptr  = (pk + 1) % N;
          m_opa  = bus.req_op_a_i[pk*DW +: DW];
          m_opb  = bus.req_op_b_i[pk*DW +: DW];
          m_lat  = hung ? 255 : L;
          if (hung) begin
            p_res = '0; p_flg = 4'b0001;
          end else begin
            r = fp_ref(m_opa, m_opb);
            p_res = r[31:0];
            p_flg = {r[32], r[33], r[34], 1'b0};
          end
        end
      end
      cyc++;
    end
  end

  task automatic do_req(input int p, input logic [31:0] a, input logic [31:0] b);
    bus.req_op_a_i[p*DW +: DW] = a;
    bus.req_op_b_i[p*DW +: DW] = b;
    bus.req_valid_i[p] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.req_ready_o[p]) begin
        @(posedge clk); #1;
        bus.req_valid_i[p] = 1'b0;
        bus.req_op_a_i[p*DW +: DW] = $urandom;
        bus.req_op_b_i[p*DW +: DW] = $urandom;
        return;
      end
    end
    tmo("accept");
    bus.req_valid_i[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (rsp_cnt >= target) return;
    end
    tmo("response");
  endtask

  task automatic wait_acc(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (acc_ids.size() >= target) return;
    end
    tmo("accept_count");
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (!bus.busy_o) return;
    end
    tmo("idle");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : stim
    int base;
    int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
    bus.req_valid_i = '0;
    bus.req_op_a_i  = '0;
    bus.req_op_b_i  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single request on port 0: 2.0 * 3.0
    base = rsp_cnt;
    do_req(0, 32'h40000000, 32'h40400000);
    wait_rsp(base + 1, 50);
    chk("t1_grant", acc_ids[acc_ids.size()-1], 0);
    chk("t1_vec", lr_vec, 4'b0001);
    chk("t1_res", lr_res, 32'h40C00000);
    chk("t1_flags", lr_flg, 4'b0000);
    chk("t1_latency", lr_cyc - last_acc, L + 2);

    // All ports pending continuously from pointer 0
    pulse_reset();
    base = acc_ids.size();
    for (int p = 0; p < N; p++) begin
      bus.req_op_a_i[p*DW +: DW] = {1'b0, 8'(127 + p), 23'h0};
      bus.req_op_b_i[p*DW +: DW] = 32'h40400000;
    end
    bus.req_valid_i = '1;
    wait_acc(base + 6, 200);
    bus.req_valid_i = '0;
    wait_idle(50);
    for (int i = 0; i < 6; i++)
      if (acc_ids.size() > base + i) chk("t2_order", acc_ids[base+i], exp_ord[i]);
      else tmo("t2_order");

    // Overflow on port 2
    base = rsp_cnt;
    do_req(2, 32'h7F000000, 32'h7F000000);
    wait_rsp(base + 1, 50);
    chk("t3_vec", lr_vec, 4'b0100);
    chk("t3_ovf", lr_flg, 4'b1000);

    // +inf * 0 on port 1
    base = rsp_cnt;
    do_req(1, 32'h7F800000, 32'h00000000);
    wait_rsp(base + 1, 50);
    chk("t4_vec", lr_vec, 4'b0010);
    chk("t4_exc", lr_flg[1], 1'b1);

    // Hung multiplier: watchdog response
    wait_idle(20);
    hung = 1'b1;
    base = rsp_cnt;
    do_req(0, 32'h40000000, 32'h40000000);
    wait_rsp(base + 1, 400);
    chk("t5_vec", lr_vec, 4'b0001);
    chk("t5_timeout", lr_flg, 4'b0001);
    chk("t5_res", lr_res, 32'h0);
    chk("t5_latency", lr_cyc - last_acc, 257);
    chk("t5_busy_drop", bus.busy_o, 1'b0);
    hung = 1'b0;

    // Reset during WAIT drops the job; pointer restarts at 0
    do_req(2, 32'h40000000, 32'h40400000);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    base = rsp_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("t6_no_rsp", rsp_cnt, base);
    base = acc_ids.size();
    bus.req_op_a_i[0*DW +: DW] = 32'h40000000;
    bus.req_op_b_i[0*DW +: DW] = 32'h40400000;
    bus.req_op_a_i[3*DW +: DW] = 32'h3F800000;
    bus.req_op_b_i[3*DW +: DW] = 32'h3F800000;
    bus.req_valid_i = 4'b1001;
    wait_acc(base + 1, 20);
    bus.req_valid_i[0] = 1'b0;
    if (acc_ids.size() > base) chk("t6_first_grant", acc_ids[base], 0);
    else tmo("t6_first_grant");
    wait_acc(base + 2, 40);
    bus.req_valid_i[3] = 1'b0;
    if (acc_ids.size() > base + 1) chk("t6_second_grant", acc_ids[base+1], 3);
    else tmo("t6_second_grant");
    wait_rsp(rsp_cnt + 1, 30);
    wait_idle(20);
    chk("t6_vec", lr_vec, 4'b1000);
    chk("t6_res", lr_res, 32'h3F800000);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
